// File: rtl/fb_pkg.sv
// fb_pkg: shared state encodings, default widths and page-select helper for the frame-buffer arbiter.
package fb_pkg;
  localparam int FB_ADDR_WIDTH = 11;
  localparam int FB_DATA_WIDTH = 48;
  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_DISP = 2'd1,
    ARB_HOST = 2'd2
  } arb_state_e;
  typedef enum logic {
    SW_IDLE    = 1'b0,
    SW_PENDING = 1'b1
  } sw_state_e;
  // The display reads the front page, the host writes the other one.
  function automatic logic fb_page(input logic front, input logic is_wr);
    return front ^ is_wr;
  endfunction
endpackage

// File: rtl/fb_rd_pipe.sv
// fb_rd_pipe: DEPTH-stage valid/tag delay line marking when a granted read returns from the RAM.
module fb_rd_pipe import fb_pkg::*; #(
  parameter int DEPTH = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_tag,
  output logic o_tag
);
  logic [DEPTH-1:0] r_sr;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_sr <= '0;
    else r_sr <= {r_sr[DEPTH-2:0], i_tag};
  assign o_tag = r_sr[DEPTH-1];
endmodule

// File: rtl/fb_arbiter.sv
// fb_arbiter: single-port frame-buffer RAM shared by a priority display reader and a starvation-protected host writer.
// Define FB_DOUBLE_BUFFER_EN for front/back page double buffering; otherwise one shown page is used.
module fb_arbiter import fb_pkg::*; #(
  parameter int ADDR_WIDTH   = FB_ADDR_WIDTH,
  parameter int DATA_WIDTH   = FB_DATA_WIDTH,
  parameter int RAM_LAT      = 1,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  clk_in,
  input  logic                  rst_n,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_gnt,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  swap_req,
  input  logic                  frame_end,
  output logic                  swap_done,
  output logic                  front_page,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_WIDTH:0]   ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);
`ifdef FB_DOUBLE_BUFFER_EN
  localparam logic DBL = 1'b1;
`else
  localparam logic DBL = 1'b0;
`endif
  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);
  arb_state_e            r_arb, w_arb_next;
  sw_state_e             r_sw, w_sw_next;
  logic [7:0]            r_starve;
  logic                  r_front, r_swap_done;
  logic [ADDR_WIDTH:0]   r_addr;
  logic [DATA_WIDTH-1:0] r_wdata, r_rd_data;
  logic                  w_force_host, w_swap, w_rd_page, w_wr_page, w_tag_out;
  // Without double buffering r_front never toggles, so both requesters land on page 0.
  assign w_rd_page = fb_page(r_front, 1'b0);
  assign w_wr_page = DBL & fb_page(r_front, 1'b1);
  always_comb begin
    w_force_host = (r_starve == LIMIT) & wr_valid;
    rd_gnt       = rd_req & ~w_force_host;
    wr_ready     = wr_valid & (~rd_req | w_force_host);
    w_arb_next   = rd_gnt ? ARB_DISP : wr_ready ? ARB_HOST : ARB_IDLE;
  end
  always_comb begin
    w_swap    = frame_end & ((r_sw == SW_PENDING) | swap_req);
    w_sw_next = (((r_sw == SW_PENDING) | swap_req) & ~frame_end) ? SW_PENDING : SW_IDLE;
  end
  always_ff @(posedge clk_in or negedge rst_n)
    if (!rst_n) begin
      r_arb       <= ARB_IDLE;
      r_sw        <= SW_IDLE;
      r_swap_done <= 1'b0;
      r_front     <= 1'b0;
      r_starve    <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rd_data   <= '0;
    end else begin
      r_arb       <= w_arb_next;
      r_sw        <= w_sw_next;
      r_swap_done <= w_swap;
      r_front     <= r_front ^ (w_swap & DBL);
      r_starve    <= (!wr_valid || wr_ready) ? '0 :
                     (rd_gnt && r_starve != LIMIT) ? r_starve + 8'd1 : r_starve;
      if (rd_gnt) r_addr <= {w_rd_page, rd_addr};
      else if (wr_ready) r_addr <= {w_wr_page, wr_addr};
      if (wr_ready) r_wdata <= wr_data;
      if (w_tag_out) r_rd_data <= ram_rdata;
    end
  fb_rd_pipe #(.DEPTH(RAM_LAT + 1)) u_rd_pipe (
    .i_clk   (clk_in),
    .i_rst_n (rst_n),
    .i_tag   (rd_gnt),
    .o_tag   (w_tag_out)
  );
  assign ram_en     = r_arb != ARB_IDLE;
  assign ram_we     = r_arb == ARB_HOST;
  assign ram_addr   = r_addr;
  assign ram_wdata  = r_wdata;
  assign swap_done  = r_swap_done;
  assign front_page = r_front;
  assign rd_valid   = w_tag_out;
  assign rd_data    = w_tag_out ? ram_rdata : r_rd_data;
endmodule

// File: tb/tb_fb_arbiter.sv
// tb_fb_arbiter: directed and random stimulus for fb_arbiter against a page/latency-level reference model.
module tb_fb_arbiter;
  localparam int AW = 11, DW = 48, LAT = 1, LIMIT = 8;
`ifdef FB_DOUBLE_BUFFER_EN
  localparam bit DBL = 1'b1;
`else
  localparam bit DBL = 1'b0;
`endif
  localparam logic [DW-1:0] A5 = 48'hA5A5A5A5A5A5;
  logic clk_in = 1'b0, rst_n = 1'b0;
  logic rd_req = 0, wr_valid = 0, swap_req = 0, frame_end = 0;
  logic [AW-1:0] rd_addr = '0, wr_addr = '0;
  logic [DW-1:0] wr_data = '0, ram_rdata, rd_data, ram_wdata;
  logic rd_gnt, rd_valid, wr_ready, swap_done, front_page, ram_en, ram_we;
  logic [AW:0] ram_addr;
  always #5 clk_in = ~clk_in;
  fb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RAM_LAT(LAT), .STARVE_LIMIT(LIMIT)) dut (
    .clk_in(clk_in), .rst_n(rst_n), .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
    .rd_valid(rd_valid), .rd_data(rd_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .swap_req(swap_req), .frame_end(frame_end),
    .swap_done(swap_done), .front_page(front_page), .ram_en(ram_en), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );
  // Behavioural single-port RAM with LAT cycles from registered command to data.
  logic [DW-1:0] mem [0:4095];
  logic [DW-1:0] pipe [LAT];
  always @(posedge clk_in) begin
    if (ram_en && ram_we) mem[ram_addr] <= ram_wdata;
    pipe[0] <= (ram_en && !ram_we) ? mem[ram_addr] : pipe[0];
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign ram_rdata = pipe[LAT-1];
  typedef struct { int due; logic [DW-1:0] data; } exp_t;
  exp_t exp_q[$];
  logic [DW-1:0] ref_mem [0:4095];
  logic [DW-1:0] m_last = '0;
  bit m_front = 0, m_pend = 0, g_wr = 0, f_old;
  int m_starve = 0, cyc = 0, n_chk = 0, n_fail = 0;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_rd_gnt"}, rd_gnt, 0);
    chk({tag, "_rd_valid"}, rd_valid, 0);
    chk({tag, "_rd_data"}, rd_data, 0);
    chk({tag, "_wr_ready"}, wr_ready, 0);
    chk({tag, "_swap_done"}, swap_done, 0);
    chk({tag, "_front_page"}, front_page, 0);
    chk({tag, "_ram_en"}, ram_en, 0);
    chk({tag, "_ram_we"}, ram_we, 0);
    chk({tag, "_ram_addr"}, ram_addr, 0);
    chk({tag, "_ram_wdata"}, ram_wdata, 0);
  endtask
  function automatic logic [DW-1:0] rand48();
    return {16'($urandom), $urandom()};
  endfunction
  // One clock cycle: check grants against the priority/starvation rules, predict the RAM command,
  // read return, swap and page outcome, then cross the edge and compare at the next negedge.
  task automatic tick();
    bit f, eg, ew, ev, rv, pg_r, pg_w, e_en, e_we;
    logic [AW:0] e_addr;
    logic [DW-1:0] e_wd;
    exp_t e;
    #2;
    f  = (m_starve == LIMIT) && wr_valid;
    eg = rd_req && !f;
    ew = wr_valid && (!rd_req || f);
    chk("rd_gnt", rd_gnt, eg);
    chk("wr_ready", wr_ready, ew);
    g_wr = wr_ready;
    pg_r = DBL ? m_front : 1'b0;
    pg_w = DBL ? !m_front : 1'b0;
    if (eg) begin
      e.due = cyc + LAT + 1;
      e.data = ref_mem[{pg_r, rd_addr}];
      exp_q.push_back(e);
    end
    if (ew) ref_mem[{pg_w, wr_addr}] = wr_data;
    e_en = eg || ew;
    e_we = ew;
    e_addr = eg ? {pg_r, rd_addr} : {pg_w, wr_addr};
    e_wd = wr_data;
    ev = frame_end && (m_pend || swap_req);
    m_pend = !frame_end && (m_pend || swap_req);
    if (ev && DBL) m_front = !m_front;
    m_starve = (!wr_valid || ew) ? 0 : (eg && m_starve < LIMIT) ? m_starve + 1 : m_starve;
    @(posedge clk_in);
    cyc++;
    @(negedge clk_in);
    chk("ram_en", ram_en, e_en);
    if (e_en) begin
      chk("ram_we", ram_we, e_we);
      chk("ram_addr", ram_addr, e_addr);
    end
    if (e_we) chk("ram_wdata", ram_wdata, e_wd);
    chk("swap_done", swap_done, ev);
    chk("front_page", front_page, m_front);
    rv = exp_q.size() > 0 && exp_q[0].due == cyc;
    chk("rd_valid", rd_valid, rv);
    if (rv) begin
      m_last = exp_q[0].data;
      void'(exp_q.pop_front());
    end
    chk("rd_data", rd_data, m_last);
  endtask
  task automatic idle_in();
    rd_req = 0; wr_valid = 0; swap_req = 0; frame_end = 0;
  endtask
  initial begin
    repeat (2) @(negedge clk_in);
    chk_zero("reset");
    rst_n = 1;
    for (int i = 0; i < 128; i++) begin
      wr_valid = 1; wr_addr = AW'(i); wr_data = (i == 5) ? A5 : rand48();
      tick();
    end
    idle_in(); tick();
    swap_req = 1; tick();
    swap_req = 1; tick();
    swap_req = 0; frame_end = 1; tick();
    frame_end = 0;
    chk("swap_pulse", swap_done, 1);
    chk("front_after_swap", front_page, DBL);
    tick();
    chk("swap_one_cycle", swap_done, 0);
    chk("single_toggle", front_page, DBL);
    rd_req = 1; rd_addr = 5; tick();
    rd_req = 0; tick();
    chk("rd5_valid", rd_valid, 1);
    chk("rd5_data", rd_data, A5);
    for (int i = 0; i < 128; i++) begin
      wr_valid = 1; wr_addr = AW'(i); wr_data = (i == 5) ? 48'h0123456789AB : rand48();
      tick();
    end
    idle_in();
    swap_req = 1; frame_end = 1; tick();
    idle_in();
    chk("imm_swap_done", swap_done, 1);
    chk("imm_front", front_page, 0);
    rd_req = 1;
    for (int i = 0; i < 128; i++) begin
      rd_addr = AW'(i);
      tick();
    end
    idle_in(); tick(); tick();
    rd_req = 1; wr_valid = 1;
    for (int i = 0; i < 36; i++) begin
      rd_addr = AW'($urandom_range(0, 127)); wr_addr = AW'($urandom_range(0, 127)); wr_data = rand48();
      tick();
      chk("starve_pattern", g_wr, (i % 9) == 8);
    end
    idle_in(); tick();
    f_old = m_front;
    wr_valid = 1; wr_addr = 9; wr_data = rand48(); swap_req = 1; frame_end = 1;
    tick();
    idle_in();
    chk("swap_cycle_wpage", ram_addr[AW], DBL & !f_old);
    chk("swap_cycle_front", front_page, DBL ^ f_old);
    for (int i = 0; i < 400; i++) begin
      rd_req = $urandom_range(0, 3) != 0; wr_valid = 1'($urandom_range(0, 1));
      rd_addr = AW'($urandom_range(0, 127)); wr_addr = AW'($urandom_range(0, 127)); wr_data = rand48();
      swap_req = $urandom_range(0, 15) == 0; frame_end = $urandom_range(0, 23) == 0;
      tick();
    end
    idle_in(); repeat (3) tick();
    rd_req = 1; rd_addr = 3; tick();
    rd_addr = 4; #2;
    chk("pre_rst_gnt", rd_gnt, 1);
    @(posedge clk_in); #1;
    rst_n = 0; idle_in();
    exp_q.delete(); m_pend = 0; m_starve = 0; m_front = 0; m_last = '0;
    @(negedge clk_in);
    chk_zero("midrst");
    @(posedge clk_in); @(negedge clk_in);
    chk_zero("midrst_hold");
    rst_n = 1;
    repeat (4) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
